pipo_rr_arbiter: RTL and testbench
==================================

PIPO_RR_ARBITER -- requirements
Module: pipo_rr_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters; fixed at 4 for this release.
REQ-002 Parameter: WIDTH, 4, data width of each requester and of the shared register.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  N_REQ  per-requester request; bit i belongs to requester i.
REQ-006 Port: din_bus  input  N_REQ*WIDTH  packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: gnt  output  N_REQ  one-hot grant pulse, one cycle wide.
REQ-008 Port: dout  output  WIDTH  shared register contents.
REQ-009 Port: dout_valid  output  1  dout holds an unconsumed transfer.
REQ-010 Port: dout_src  output  2  index of the requester whose data is in dout.
REQ-011 Port: dout_ack  input  1  consumer accepts dout; only meaningful while dout_valid=1.
REQ-012 Port: xfer_cnt  output  8  count of completed (acknowledged) transfers.

Function
REQ-013 The FSM SHALL have two states: IDLE and HOLD.
REQ-014 IDLE, req==0: SHALL remain in IDLE, with gnt=0 and dout_valid=0.
REQ-015 IDLE, req!=0: on that edge the block SHALL select winner w by round-robin.
REQ-016 Round-robin search SHALL start at pointer ptr and proceed ptr, ptr+1, ... mod 4; the first set req bit wins.
REQ-017 On that same edge the block SHALL:
- load dout <= din_bus slice w;
- set dout_src <= w;
- set gnt <= one-hot(w) for exactly one cycle;
- set dout_valid <= 1;
- enter HOLD.
REQ-018 Latency SHALL be one cycle: req sampled at edge k gives gnt, dout and dout_valid updated after edge k.
REQ-019 HOLD, dout_ack=0: dout, dout_src and dout_valid SHALL hold; gnt SHALL be 0; req changes SHALL be ignored.
REQ-020 HOLD, dout_ack=1: at the edge the block SHALL:
- clear dout_valid;
- set ptr <= (dout_src+1) mod 4;
- increment xfer_cnt;
- return to IDLE.
REQ-021 dout SHALL retain its last value after acknowledge; it changes only on a new grant.
REQ-022 dout_ack is permitted in the same cycle as the gnt pulse and SHALL be honoured.
REQ-023 dout_ack while dout_valid=0 SHALL be ignored: no state, pointer or counter change.
REQ-024 Minimum spacing between grants SHALL be 2 cycles (grant, ack, grant).
REQ-025 A requester holding req high after its grant SHALL be treated as a new request, subject to rotation.
REQ-026 With all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0,...; no requester waits more than 3 transfers.
REQ-027 xfer_cnt SHALL wrap from 255 to 0 with no flag.
REQ-028 Pointer arithmetic SHALL be 2-bit modulo 4; winner 3 gives ptr=0.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL set state=IDLE, gnt=0, dout=0, dout_valid=0, dout_src=0, ptr=0, xfer_cnt=0.
REQ-030 Reset SHALL override all other inputs, including a simultaneous req or dout_ack.
REQ-031 Reset asserted in HOLD SHALL abandon the pending transfer: it is not counted and no grant is reissued.
REQ-032 After reset deasserts, the first grant SHALL follow REQ-016 with ptr=0.

Verification
REQ-033 Reset, then req=4'b0100, din_bus slice2=4'hA, dout_ack held 0. Required: next cycle gnt=4'b0100, dout=4'hA, dout_src=2, dout_valid=1; these hold for 5 cycles; gnt=0 after its first cycle.
REQ-034 req=4'b1111 held, dout_ack=1 continuous, slices 0..3 = 4'h1,4'h2,4'h3,4'h4. Required: gnt sequence 0001,0010,0100,1000,0001 every 2 cycles; dout 1,2,3,4,1; xfer_cnt increments per ack.
REQ-035 Winner 3 acknowledged, then req=4'b1001. Required: requester 0 granted (ptr wrapped to 0).
REQ-036 Assert reset in HOLD with dout=4'h7 and dout_ack=1 in the same cycle. Required: next cycle dout=0, dout_valid=0, xfer_cnt unchanged from 0, ptr=0.
REQ-037 Pulse dout_ack while idle. Required: no change to xfer_cnt or ptr.
REQ-038 Complete 256 acknowledged transfers. Required: xfer_cnt returns to 0.

Source files
------------

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter feeding a single shared output register.
// A winner's data is held in dout until the consumer acknowledges it.
module pipo_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [1:0]             dout_src,
  input  logic                   dout_ack,
  output logic [7:0]             xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         src_q, src_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         scan_idx;

  // Scan starting at the pointer; the first active request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    dout_d  = dout_q;
    gnt_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          dout_d  = din_bus[win_idx*WIDTH +: WIDTH];
          src_d   = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // dout is left untouched on acknowledge; only a new grant reloads it.
        if (dout_ack) begin
          ptr_d   = src_q + 2'd1;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      dout_q  <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      dout_q  <= dout_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = (state_q == HOLD);
  assign dout_src   = src_q;
  assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed checks of pipo_rr_arbiter: grant latency, hold, rotation,
// pointer wrap, idle acknowledge, reset in HOLD and counter wrap.
module tb_pipo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] din_bus;
  logic [3:0]  gnt;
  logic [3:0]  dout;
  logic        dout_valid;
  logic [1:0]  dout_src;
  logic        dout_ack;
  logic [7:0]  xfer_cnt;

  int checks = 0;
  int errors = 0;

  pipo_rr_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .din_bus    (din_bus),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_src   (dout_src),
    .dout_ack   (dout_ack),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_dout,
                           input logic e_valid, input logic [1:0] e_src, input logic [7:0] e_cnt);
    chk({tag, ".gnt"},   16'(gnt),        16'(e_gnt));
    chk({tag, ".dout"},  16'(dout),       16'(e_dout));
    chk({tag, ".valid"}, 16'(dout_valid), 16'(e_valid));
    chk({tag, ".src"},   16'(dout_src),   16'(e_src));
    chk({tag, ".cnt"},   16'(xfer_cnt),   16'(e_cnt));
    $display("t=%0t %s gnt=%b dout=%h valid=%b src=%0d cnt=%0d",
             $time, tag, gnt, dout, dout_valid, dout_src, xfer_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    din_bus  = 16'h0000;
    dout_ack = 1'b0;

    // Reset state
    do_reset();
    chk_state("reset", 4'b0000, 4'h0, 1'b0, 2'd0, 8'd0);

    // Single request from requester 2, consumer stalls
    req     = 4'b0100;
    din_bus = 16'h0A00;
    step();
    chk_state("grant2", 4'b0100, 4'hA, 1'b1, 2'd2, 8'd0);
    req     = 4'b0011;
    din_bus = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_state("hold2", 4'b0000, 4'hA, 1'b1, 2'd2, 8'd0);
    end

    // Acknowledge: ptr becomes 3, dout retained
    req      = 4'b0000;
    dout_ack = 1'b1;
    step();
    chk_state("ack2", 4'b0000, 4'hA, 1'b0, 2'd2, 8'd1);

    // Acknowledge while idle is ignored
    step();
    step();
    chk_state("idle_ack", 4'b0000, 4'hA, 1'b0, 2'd2, 8'd1);
    dout_ack = 1'b0;

    // ptr=3 (idle ack must not have moved it): requester 3 beats 0
    req     = 4'b1001;
    din_bus = 16'h300C;
    step();
    chk_state("grant3", 4'b1000, 4'h3, 1'b1, 2'd3, 8'd1);
    dout_ack = 1'b1;
    req      = 4'b0000;
    step();
    chk_state("ack3", 4'b0000, 4'h3, 1'b0, 2'd3, 8'd2);
    dout_ack = 1'b0;

    // Pointer wrapped to 0: requester 0 now beats 3
    req = 4'b1001;
    step();
    chk_state("wrap0", 4'b0001, 4'hC, 1'b1, 2'd0, 8'd2);
    dout_ack = 1'b1;
    req      = 4'b0000;
    step();
    chk_state("ack0", 4'b0000, 4'hC, 1'b0, 2'd0, 8'd3);
    dout_ack = 1'b0;

    // Full contention, ack continuously asserted: rotation 0,1,2,3,0
    do_reset();
    req      = 4'b1111;
    din_bus  = 16'h4321;
    dout_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_state("rot_gnt", 4'(1 << (k % 4)), 4'(k % 4 + 1), 1'b1, 2'(k % 4), 8'(k));
      step();
      chk_state("rot_ack", 4'b0000, 4'(k % 4 + 1), 1'b0, 2'(k % 4), 8'(k + 1));
    end

    // Reset in HOLD with simultaneous ack abandons the transfer
    req      = 4'b0000;
    dout_ack = 1'b0;
    do_reset();
    req     = 4'b0001;
    din_bus = 16'h0007;
    step();
    chk_state("pre_rst", 4'b0001, 4'h7, 1'b1, 2'd0, 8'd0);
    reset    = 1'b1;
    dout_ack = 1'b1;
    req      = 4'b0000;
    step();
    reset    = 1'b0;
    dout_ack = 1'b0;
    chk_state("rst_hold", 4'b0000, 4'h0, 1'b0, 2'd0, 8'd0);
    step();
    chk_state("no_reissue", 4'b0000, 4'h0, 1'b0, 2'd0, 8'd0);
    req     = 4'b1111;
    din_bus = 16'h4321;
    step();
    chk_state("post_rst", 4'b0001, 4'h1, 1'b1, 2'd0, 8'd0);

    // 256 acknowledged transfers wrap the counter
    req = 4'b0000;
    do_reset();
    req      = 4'b0001;
    din_bus  = 16'h0009;
    dout_ack = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step();
      step();
    end
    chk("cnt255", 16'(xfer_cnt), 16'd255);
    step();
    step();
    chk("cnt_wrap", 16'(xfer_cnt), 16'd0);
    $display("t=%0t cnt_wrap cnt=%0d", $time, xfer_cnt);
    dout_ack = 1'b0;
    req      = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
